id_ex_pipe_reg: RTL and testbench

Parametrised ID/EX pipeline register with valid tracking, stall hold, flush-to-bubble and internal operand forwarding. Forwarding uses register-index comparison against NUM_FWD prioritised writeback sources. While the stage is stalled, held operands keep tracking those sources, so a value is never stale when the stall releases. Sits between the decode/register-file read and the ALU stage of the pipelined core.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/fwd_select.sv | 33 +++
 rtl/id_ex_pipe_reg.sv | 142 ++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: datapath widths, control bundle bit positions
// and instruction field slices used by the ID/EX stage.
package pipe_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;

   // Control bundle: {MemRead, MemtoReg, MemWrite, RegWrite, ALUSrc, ALUOp[2:0], spare}
   localparam int CTRL_W         = 9;
   localparam int CTRL_MEMREAD   = 8;
   localparam int CTRL_MEMTOREG  = 7;
   localparam int CTRL_MEMWRITE  = 6;
   localparam int CTRL_REGWRITE  = 5;
   localparam int CTRL_ALUSRC    = 4;
   localparam int CTRL_ALUOP_MSB = 3;
   localparam int CTRL_ALUOP_LSB = 1;
   localparam int CTRL_SPARE     = 0;

   localparam int FUNC3_LSB = 12;
   localparam int FUNC3_W   = 3;
   localparam int FUNC7_LSB = 25;
   localparam int FUNC7_W   = 7;

endpackage

// File: rtl/fwd_select.sv
// Priority forwarding mux: returns the lowest-numbered writeback source whose
// destination matches idx, else the default data. Register x0 never matches.
module fwd_select
   import pipe_pkg::*;
#(
   parameter int DATA_W  = pipe_pkg::XLEN,
   parameter int NUM_FWD = 2
) (
   input  logic [REG_IDX_W-1:0]         idx,
   input  logic [DATA_W-1:0]            dflt_data,
   input  logic [NUM_FWD-1:0]           fwd_valid,
   input  logic [NUM_FWD*REG_IDX_W-1:0] fwd_rd,
   input  logic [NUM_FWD*DATA_W-1:0]    fwd_data,
   output logic [DATA_W-1:0]            sel_data,
   output logic                         hit
);

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      sel_data = dflt_data;
      hit      = 1'b0;
      // Walk from lowest priority to highest so the youngest match is written last.
      if (idx != '0) begin
         for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_valid[k] && (fwd_rd[k*REG_IDX_W +: REG_IDX_W] == idx)) begin
               sel_data = fwd_data[k*DATA_W +: DATA_W];
               hit      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall hold, flush-to-bubble and operand forwarding
// that keeps refreshing held operands during stalls. Define ID_EX_STATS_EN for counters.
module id_ex_pipe_reg
   import pipe_pkg::*;
#(
   parameter int XLEN    = pipe_pkg::XLEN,
   parameter int NUM_SRC = 2,
   parameter int NUM_FWD = 2,
   parameter int CTRL_W  = pipe_pkg::CTRL_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         stall_i,
   input  logic                         flush_i,
   input  logic                         in_valid_i,
   input  logic [CTRL_W-1:0]            ctrl_i,
   input  logic [31:0]                  instr_i,
   input  logic [NUM_SRC*REG_IDX_W-1:0] rs_idx_i,
   input  logic [NUM_SRC*XLEN-1:0]      rs_data_i,
   input  logic [XLEN-1:0]              imm_i,
   input  logic [REG_IDX_W-1:0]         rd_i,
   input  logic [NUM_FWD-1:0]           fwd_valid_i,
   input  logic [NUM_FWD*REG_IDX_W-1:0] fwd_rd_i,
   input  logic [NUM_FWD*XLEN-1:0]      fwd_data_i,
   output logic                         out_valid_o,
   output logic [CTRL_W-1:0]            ctrl_o,
   output logic [NUM_SRC*XLEN-1:0]      rs_data_o,
   output logic [XLEN-1:0]              imm_o,
   output logic [FUNC3_W-1:0]           func3_o,
   output logic [FUNC7_W-1:0]           func7_o,
   output logic [REG_IDX_W-1:0]         rd_o,
`ifdef ID_EX_STATS_EN
   output logic [31:0]                  stall_cnt_o,
   output logic [31:0]                  bubble_cnt_o,
`endif
   output logic [NUM_SRC-1:0]           fwd_hit_o
);

   logic [REG_IDX_W-1:0] rs_idx_q  [NUM_SRC];
   logic [XLEN-1:0]      rs_data_q [NUM_SRC];
   logic [XLEN-1:0]      ld_data   [NUM_SRC];
   logic [XLEN-1:0]      rf_data   [NUM_SRC];
   logic [NUM_SRC-1:0]   ld_hit;
   logic [NUM_SRC-1:0]   rf_hit;
   logic                 take_bubble;
   logic                 unused_instr;

   assign take_bubble  = flush_i || (!stall_i && !in_valid_i);
   assign unused_instr = ^{instr_i[FUNC7_LSB-1:FUNC3_LSB+FUNC3_W], instr_i[FUNC3_LSB-1:0]};

   // Load path selects from the incoming slot; refresh path from the held operand.
   for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
      fwd_select #(.DATA_W(XLEN), .NUM_FWD(NUM_FWD)) u_ld_sel (
         .idx       (rs_idx_i[j*REG_IDX_W +: REG_IDX_W]),
         .dflt_data (rs_data_i[j*XLEN +: XLEN]),
         .fwd_valid (fwd_valid_i),
         .fwd_rd    (fwd_rd_i),
         .fwd_data  (fwd_data_i),
         .sel_data  (ld_data[j]),
         .hit       (ld_hit[j])
      );

      fwd_select #(.DATA_W(XLEN), .NUM_FWD(NUM_FWD)) u_rf_sel (
         .idx       (rs_idx_q[j]),
         .dflt_data (rs_data_q[j]),
         .fwd_valid (fwd_valid_i),
         .fwd_rd    (fwd_rd_i),
         .fwd_data  (fwd_data_i),
         .sel_data  (rf_data[j]),
         .hit       (rf_hit[j])
      );

      assign rs_data_o[j*XLEN +: XLEN] = rs_data_q[j];
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_o <= 1'b0;
         ctrl_o      <= '0;
         imm_o       <= '0;
         func3_o     <= '0;
         func7_o     <= '0;
         rd_o        <= '0;
         fwd_hit_o   <= '0;
         for (int j = 0; j < NUM_SRC; j++) begin
            rs_idx_q[j]  <= '0;
            rs_data_q[j] <= '0;
         end
      end else if (take_bubble) begin
         out_valid_o <= 1'b0;
         ctrl_o      <= '0;
         imm_o       <= '0;
         func3_o     <= '0;
         func7_o     <= '0;
         rd_o        <= '0;
         fwd_hit_o   <= '0;
         for (int j = 0; j < NUM_SRC; j++) begin
            rs_idx_q[j]  <= '0;
            rs_data_q[j] <= '0;
         end
      end else if (stall_i) begin
         for (int j = 0; j < NUM_SRC; j++) begin
            if (out_valid_o && rf_hit[j]) begin
               rs_data_q[j] <= rf_data[j];
               fwd_hit_o[j] <= 1'b1;
            end
         end
      end else begin
         out_valid_o <= 1'b1;
         ctrl_o      <= ctrl_i;
         imm_o       <= imm_i;
         func3_o     <= instr_i[FUNC3_LSB +: FUNC3_W];
         func7_o     <= instr_i[FUNC7_LSB +: FUNC7_W];
         rd_o        <= rd_i;
         fwd_hit_o   <= ld_hit;
         for (int j = 0; j < NUM_SRC; j++) begin
            rs_idx_q[j]  <= rs_idx_i[j*REG_IDX_W +: REG_IDX_W];
            rs_data_q[j] <= ld_data[j];
         end
      end
   end

`ifdef ID_EX_STATS_EN
   logic count_stall;
   assign count_stall = stall_i && !flush_i && out_valid_o;

   // Both counters saturate at all-ones rather than wrapping.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_o  <= '0;
         bubble_cnt_o <= '0;
      end else begin
         if (count_stall && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + 32'd1;
         if (take_bubble && (bubble_cnt_o != '1))
            bubble_cnt_o <= bubble_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios plus randomized
// traffic compared against a behavioural model of the stage.
module tb_id_ex_pipe_reg;

   localparam int XLEN    = 32;
   localparam int NUM_SRC = 2;
   localparam int NUM_FWD = 2;
   localparam int CTRL_W  = 9;

   logic                    clk;
   logic                    rst;
   logic                    stall_i;
   logic                    flush_i;
   logic                    in_valid_i;
   logic [CTRL_W-1:0]       ctrl_i;
   logic [31:0]             instr_i;
   logic [NUM_SRC*5-1:0]    rs_idx_i;
   logic [NUM_SRC*XLEN-1:0] rs_data_i;
   logic [XLEN-1:0]         imm_i;
   logic [4:0]              rd_i;
   logic [NUM_FWD-1:0]      fwd_valid_i;
   logic [NUM_FWD*5-1:0]    fwd_rd_i;
   logic [NUM_FWD*XLEN-1:0] fwd_data_i;
   logic                    out_valid_o;
   logic [CTRL_W-1:0]       ctrl_o;
   logic [NUM_SRC*XLEN-1:0] rs_data_o;
   logic [XLEN-1:0]         imm_o;
   logic [2:0]              func3_o;
   logic [6:0]              func7_o;
   logic [4:0]              rd_o;
   logic [NUM_SRC-1:0]      fwd_hit_o;
`ifdef ID_EX_STATS_EN
   logic [31:0]             stall_cnt_o;
   logic [31:0]             bubble_cnt_o;
`endif

   id_ex_pipe_reg #(
      .XLEN(XLEN), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .CTRL_W(CTRL_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall_i     (stall_i),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .ctrl_i      (ctrl_i),
      .instr_i     (instr_i),
      .rs_idx_i    (rs_idx_i),
      .rs_data_i   (rs_data_i),
      .imm_i       (imm_i),
      .rd_i        (rd_i),
      .fwd_valid_i (fwd_valid_i),
      .fwd_rd_i    (fwd_rd_i),
      .fwd_data_i  (fwd_data_i),
      .out_valid_o (out_valid_o),
      .ctrl_o      (ctrl_o),
      .rs_data_o   (rs_data_o),
      .imm_o       (imm_o),
      .func3_o     (func3_o),
      .func7_o     (func7_o),
      .rd_o        (rd_o),
`ifdef ID_EX_STATS_EN
      .stall_cnt_o (stall_cnt_o),
      .bubble_cnt_o(bubble_cnt_o),
`endif
      .fwd_hit_o   (fwd_hit_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic              m_valid;
   logic [CTRL_W-1:0] m_ctrl;
   logic [XLEN-1:0]   m_imm;
   logic [31:0]       m_instr;
   logic [4:0]        m_rd;
   logic [4:0]        m_idx  [NUM_SRC];
   logic [XLEN-1:0]   m_data [NUM_SRC];
   logic              m_hit  [NUM_SRC];
   logic [31:0]       m_stall_cnt;
   logic [31:0]       m_bubble_cnt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Youngest writeback (lowest k) carrying register idx, ignoring x0.
   task automatic forward_lookup(input logic [4:0] idx, output logic found, output logic [XLEN-1:0] val);
      found = 1'b0;
      val   = '0;
      if (idx != 5'd0) begin
         for (int k = 0; k < NUM_FWD; k++) begin
            if (!found && fwd_valid_i[k] && fwd_rd_i[k*5 +: 5] == idx) begin
               found = 1'b1;
               val   = fwd_data_i[k*XLEN +: XLEN];
            end
         end
      end
   endtask

   task automatic model_clear();
      m_valid = 1'b0;
      m_ctrl  = '0;
      m_imm   = '0;
      m_instr = '0;
      m_rd    = '0;
      for (int j = 0; j < NUM_SRC; j++) begin
         m_idx[j]  = '0;
         m_data[j] = '0;
         m_hit[j]  = 1'b0;
      end
   endtask

   task automatic model_reset();
      model_clear();
      m_stall_cnt  = '0;
      m_bubble_cnt = '0;
   endtask

   task automatic model_edge();
      logic            f;
      logic [XLEN-1:0] v;
      if (flush_i || (!stall_i && !in_valid_i)) begin
         model_clear();
         if (m_bubble_cnt != 32'hFFFF_FFFF) m_bubble_cnt = m_bubble_cnt + 1;
      end else if (stall_i) begin
         if (m_valid) begin
            if (m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 1;
            for (int j = 0; j < NUM_SRC; j++) begin
               forward_lookup(m_idx[j], f, v);
               if (f) begin
                  m_data[j] = v;
                  m_hit[j]  = 1'b1;
               end
            end
         end
      end else begin
         m_valid = 1'b1;
         m_ctrl  = ctrl_i;
         m_imm   = imm_i;
         m_instr = instr_i;
         m_rd    = rd_i;
         for (int j = 0; j < NUM_SRC; j++) begin
            m_idx[j] = rs_idx_i[j*5 +: 5];
            forward_lookup(m_idx[j], f, v);
            m_data[j] = f ? v : rs_data_i[j*XLEN +: XLEN];
            m_hit[j]  = f;
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = m_valid ? m_instr[14:12] : 3'd0;
      f7 = m_valid ? m_instr[31:25] : 7'd0;
      check({tag, ".valid"}, 64'(out_valid_o), 64'(m_valid));
      check({tag, ".ctrl"},  64'(ctrl_o),      64'(m_ctrl));
      check({tag, ".imm"},   64'(imm_o),       64'(m_imm));
      check({tag, ".func3"}, 64'(func3_o),     64'(f3));
      check({tag, ".func7"}, 64'(func7_o),     64'(f7));
      check({tag, ".rd"},    64'(rd_o),        64'(m_rd));
      for (int j = 0; j < NUM_SRC; j++) begin
         check($sformatf("%s.rs_data%0d", tag, j), 64'(rs_data_o[j*XLEN +: XLEN]), 64'(m_data[j]));
         check($sformatf("%s.fwd_hit%0d", tag, j), 64'(fwd_hit_o[j]), 64'(m_hit[j]));
      end
`ifdef ID_EX_STATS_EN
      check({tag, ".stall_cnt"},  64'(stall_cnt_o),  64'(m_stall_cnt));
      check({tag, ".bubble_cnt"}, 64'(bubble_cnt_o), 64'(m_bubble_cnt));
`endif
   endtask

   // One active (falling) edge, then sample just after it.
   task automatic step(input string tag);
      @(negedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic quiet_inputs();
      stall_i     = 1'b0;
      flush_i     = 1'b0;
      in_valid_i  = 1'b1;
      fwd_valid_i = '0;
      fwd_rd_i    = '0;
      fwd_data_i  = '0;
      rs_idx_i    = '0;
      rs_data_i   = '0;
      ctrl_i      = CTRL_W'($urandom);
      instr_i     = $urandom;
      imm_i       = $urandom;
      rd_i        = 5'($urandom);
   endtask

   task automatic random_inputs();
      stall_i    = ($urandom_range(0, 3) == 0);
      flush_i    = ($urandom_range(0, 9) == 0);
      in_valid_i = ($urandom_range(0, 4) != 0);
      ctrl_i     = CTRL_W'($urandom);
      instr_i    = $urandom;
      imm_i      = $urandom;
      rd_i       = 5'($urandom);
      fwd_valid_i = NUM_FWD'($urandom);
      for (int j = 0; j < NUM_SRC; j++) begin
         rs_idx_i[j*5 +: 5]        = 5'($urandom_range(0, 3));
         rs_data_i[j*XLEN +: XLEN] = $urandom;
      end
      for (int k = 0; k < NUM_FWD; k++) begin
         fwd_rd_i[k*5 +: 5]         = 5'($urandom_range(0, 3));
         fwd_data_i[k*XLEN +: XLEN] = $urandom;
      end
   endtask

   initial begin
      rst = 1'b0;
      quiet_inputs();
      in_valid_i = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      @(posedge clk);
      rst = 1'b1;

      // Plain load, no forwarding
      quiet_inputs();
      rs_idx_i  = {5'd6, 5'd5};
      rs_data_i = {32'h22, 32'h11};
      step("plain");
      check("plain.op0_const", 64'(rs_data_o[31:0]), 64'h11);
      check("plain.hit_const", 64'(fwd_hit_o), 64'h0);

      // Both sources target x5: source 0 wins
      quiet_inputs();
      rs_idx_i    = {5'd0, 5'd5};
      rs_data_i   = {32'h0, 32'h11};
      fwd_valid_i = 2'b11;
      fwd_rd_i    = {5'd5, 5'd5};
      fwd_data_i  = {32'hBBBB, 32'hAAAA};
      step("prio");
      check("prio.op0_const", 64'(rs_data_o[31:0]), 64'hAAAA);

      // x0 never forwards
      quiet_inputs();
      rs_idx_i    = {5'd0, 5'd0};
      fwd_valid_i = 2'b01;
      fwd_rd_i    = {5'd0, 5'd0};
      fwd_data_i  = {32'h0, 32'hDEAD};
      step("x0");
      check("x0.op0_const", 64'(rs_data_o[31:0]), 64'h0);

      // Stall refresh: x7 held, source 1 writes it during the second stalled edge
      quiet_inputs();
      rs_idx_i  = {5'd0, 5'd7};
      rs_data_i = {32'h0, 32'h1};
      step("stall_ld");
      stall_i = 1'b1;
      ctrl_i  = ~ctrl_i;
      step("stall_c1");
      fwd_valid_i = 2'b10;
      fwd_rd_i    = {5'd7, 5'd0};
      fwd_data_i  = {32'h42, 32'h0};
      step("stall_c2");
      check("stall.op0_const", 64'(rs_data_o[31:0]), 64'h42);
      fwd_valid_i = '0;
      step("stall_c3");
      quiet_inputs();
      rs_idx_i  = {5'd3, 5'd4};
      rs_data_i = {32'h33, 32'h44};
      step("release");

      // Flush together with stall
      stall_i = 1'b1;
      flush_i = 1'b1;
      step("flush_stall");

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         random_inputs();
         step("rand");
      end

      // Asynchronous reset mid-cycle while holding a valid instruction
      quiet_inputs();
      step("pre_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      stall_i = 1'b1;
      @(posedge clk);
      rst = 1'b1;
      step("rst_stall");
      stall_i = 1'b0;
      step("rst_load");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Backstop so the run always ends, even if a wait never returns.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, errors %0d", errors);
      $fatal(1, "timeout");
   end

endmodule
